// File: rtl/ppa_sklansky_sub_pipe.sv
// Two-stage pipelined subtractor D = A - B - bin on a Sklansky carry tree, valid/ready handshake.
// Define PPA_SUB_OVF_EN to add the registered signed-overflow output ovf.
module ppa_sklansky_sub_pipe #(
  parameter int width = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] D,
  output logic             bout,
`ifdef PPA_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int levels = $clog2(width);
  localparam int split  = levels / 2;

  // Group-generate after the Sklansky levels in [lo, hi); level k joins every bit
  // whose index has bit k set with the top bit of the block just below it.
  function automatic logic [width-1:0] sk_g(input logic [width-1:0] g, input logic [width-1:0] p,
                                            input int lo, input int hi);
    logic [width-1:0] gc, pc, gn, pn;
    int j;
    gc = g;
    pc = p;
    for (int k = 0; k < levels; k++) begin
      gn = gc;
      pn = pc;
      if ((k >= lo) && (k < hi)) begin
        for (int i = 0; i < width; i++) begin
          if (((i >> k) & 32'sd1) != 32'sd0) begin
            j     = ((i >> k) << k) - 32'sd1;
            gn[i] = gc[i] | (pc[i] & gc[j]);
            pn[i] = pc[i] & pc[j];
          end else begin
            gn[i] = gc[i];
            pn[i] = pc[i];
          end
        end
      end else begin
        gn = gc;
        pn = pc;
      end
      gc = gn;
      pc = pn;
    end
    return gc;
  endfunction

  // Group-propagate after the Sklansky levels in [lo, hi).
  function automatic logic [width-1:0] sk_p(input logic [width-1:0] p, input int lo, input int hi);
    logic [width-1:0] pc, pn;
    int j;
    pc = p;
    for (int k = 0; k < levels; k++) begin
      pn = pc;
      if ((k >= lo) && (k < hi)) begin
        for (int i = 0; i < width; i++) begin
          if (((i >> k) & 32'sd1) != 32'sd0) begin
            j     = ((i >> k) << k) - 32'sd1;
            pn[i] = pc[i] & pc[j];
          end else begin
            pn[i] = pc[i];
          end
        end
      end else begin
        pn = pc;
      end
      pc = pn;
    end
    return pc;
  endfunction

  logic [width-1:0] g0_s, p0_s, g1_s, p1_s;
  logic [width-1:0] g1_r, p1_r, pr_r;
  logic             cin_r, v1_r, v2_r;
  logic [width-1:0] gf_s, d_s, d_r;
  logic             bout_s, bout_r, s2_load_s;
`ifdef PPA_SUB_OVF_EN
  logic             ovf_s, ovf_r;
`endif

  assign in_ready  = !v1_r || !v2_r || out_ready;
  assign s2_load_s = !v2_r || out_ready;
  assign out_valid = v2_r;
  assign D         = d_r;
  assign bout      = bout_r;
`ifdef PPA_SUB_OVF_EN
  assign ovf       = ovf_r;
`endif

  // Stage 1 terms: A + ~B with carry-in ~bin folded into bit 0's generate.
  always_comb begin
    p0_s    = A ^ ~B;
    g0_s    = A & ~B;
    g0_s[0] = g0_s[0] | (p0_s[0] & ~bin);
    g1_s    = sk_g(g0_s, p0_s, 0, split);
    p1_s    = sk_p(p0_s, 0, split);
  end

  // Stage 2 terms: finish the carry tree, form sum bits and borrow.
  always_comb begin
    gf_s   = sk_g(g1_r, p1_r, split, levels);
    d_s    = pr_r ^ {gf_s[width-2:0], cin_r};
    bout_s = ~gf_s[width-1];
`ifdef PPA_SUB_OVF_EN
    ovf_s  = gf_s[width-1] ^ gf_s[width-2];
`endif
  end

  // Stage 1 register: accepts whenever in_ready is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      g1_r  <= '0;
      p1_r  <= '0;
      pr_r  <= '0;
      cin_r <= 1'b0;
    end else if (in_ready) begin
      v1_r <= in_valid;
      if (in_valid) begin
        g1_r  <= g1_s;
        p1_r  <= p1_s;
        pr_r  <= p0_s;
        cin_r <= ~bin;
      end
    end
  end

  // Stage 2 register: loads when empty or drained this cycle, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      d_r    <= '0;
      bout_r <= 1'b0;
`ifdef PPA_SUB_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else if (s2_load_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        d_r    <= d_s;
        bout_r <= bout_s;
`ifdef PPA_SUB_OVF_EN
        ovf_r  <= ovf_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ppa_sklansky_sub_pipe.sv
// Directed + random bench for ppa_sklansky_sub_pipe; arithmetic reference model and in-flight queue.
module tb_ppa_sklansky_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] A, B, D;
  logic        bin, in_valid, in_ready, bout, out_valid, out_ready;
`ifdef PPA_SUB_OVF_EN
  logic        ovf;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [16:0] d;
    logic        bout;
    logic        ovf;
    int          acc;
  } item_t;
  item_t q[$];

  ppa_sklansky_sub_pipe #(.width(17)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .bin(bin),
    .in_valid(in_valid), .in_ready(in_ready), .D(D), .bout(bout),
`ifdef PPA_SUB_OVF_EN
    .ovf(ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, bout, D} from plain integer arithmetic.
  function automatic logic [18:0] ref_sub(input logic [16:0] a, input logic [16:0] b, input logic bi);
    longint u, s;
    logic [18:0] r;
    u = longint'(a) - longint'(b) - longint'(bi);
    s = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    r[16:0] = u[16:0];
    r[17]   = (u < 64'sd0);
    r[18]   = (s < -64'sd65536) || (s > 64'sd65535);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the queue, update the model at the edge.
  task automatic step(input bit iv, input logic [16:0] a, input logic [16:0] b, input bit bi,
                      input bit ordy, output bit acc);
    bit exp_ov, exp_ir, cons;
    logic [18:0] r;
    item_t it;
    @(negedge clk);
    in_valid = iv; A = a; B = b; bin = bi; out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    if (exp_ov) begin
      chk("D", {47'd0, D}, {47'd0, q[0].d});
      chk("bout", {63'd0, bout}, {63'd0, q[0].bout});
`ifdef PPA_SUB_OVF_EN
      chk("ovf", {63'd0, ovf}, {63'd0, q[0].ovf});
`endif
    end
    exp_ir = (q.size() < 2) || ordy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    acc  = iv && exp_ir;
    cons = exp_ov && ordy;
    @(posedge clk);
    if (cons) void'(q.pop_front());
    if (acc) begin
      r       = ref_sub(a, b, bi);
      it.d    = r[16:0];
      it.bout = r[17];
      it.ovf  = r[18];
      it.acc  = cyc;
      q.push_back(it);
    end
    cyc++;
  endtask

  initial begin
    bit acc;
    logic [18:0] r;
    logic [16:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; A = 17'd0; B = 17'd0; bin = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_D", {47'd0, D}, 64'd0);
    chk("rst_bout", {63'd0, bout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pin the model with hand-computed values.
    r = ref_sub(17'h00005, 17'h00003, 1'b0);
    chk("model_basic", {45'd0, r}, {45'd0, 1'b0, 1'b0, 17'h00002});
    r = ref_sub(17'h00000, 17'h00001, 1'b0);
    chk("model_wrap0", {46'd0, r[17:0]}, {46'd0, 1'b1, 17'h1FFFF});
    r = ref_sub(17'h1FFFF, 17'h1FFFF, 1'b1);
    chk("model_wrap1", {46'd0, r[17:0]}, {46'd0, 1'b1, 17'h1FFFF});
    r = ref_sub(17'h0FFFF, 17'h10000, 1'b0);
    chk("model_ovf", {63'd0, r[18]}, 64'd1);

    // Basic, wrap-around and overflow vectors, then drain.
    step(1'b1, 17'h00005, 17'h00003, 1'b0, 1'b1, acc);
    step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);
    step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);
    chk("basic_D_lit", {47'd0, D}, 64'h2);
    step(1'b1, 17'h00000, 17'h00001, 1'b0, 1'b1, acc);
    step(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b1, 1'b1, acc);
    step(1'b1, 17'h0FFFF, 17'h10000, 1'b0, 1'b1, acc);
    step(1'b1, 17'h10000, 17'h00001, 1'b1, 1'b1, acc);
    repeat (3) step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);

    // Sustained throughput.
    for (int i = 0; i < 10; i++) step(1'b1, 17'(i * 977), 17'(i * 3001), i[0], 1'b1, acc);
    repeat (3) step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);

    // Backpressure: third request blocked until out_ready rises.
    step(1'b1, 17'h00100, 17'h00001, 1'b0, 1'b0, acc);
    step(1'b1, 17'h00200, 17'h00002, 1'b1, 1'b0, acc);
    step(1'b1, 17'h00300, 17'h00400, 1'b0, 1'b0, acc);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    step(1'b1, 17'h00300, 17'h00400, 1'b0, 1'b0, acc);
    chk("bp_D_hold", {47'd0, D}, 64'h000FF);
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) step(1'b1, 17'h00300, 17'h00400, 1'b0, 1'b1, acc);
    chk("bp_accept", {63'd0, acc}, 64'd1);
    repeat (4) step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);

    // Reset mid-flight.
    step(1'b1, 17'h00011, 17'h00001, 1'b0, 1'b0, acc);
    step(1'b1, 17'h00022, 17'h00002, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_D", {47'd0, D}, 64'd0);
    q.delete();
    #1 rst_n = 1'b1;
    repeat (4) step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);

    // Random soak.
    for (int i = 0; i < 1000; i++) begin
      ra = 17'($urandom);
      rb = 17'($urandom);
      step(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    end
    repeat (5) step(1'b0, 17'h00000, 17'h00000, 1'b0, 1'b1, acc);
    chk("drained", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ppa_sklansky_sub_pipe.md
PPA_SKLANSKY_SUB_PIPE -- requirements
Module: ppa_sklansky_sub_pipe

Interface
REQ-001 The block SHALL have parameter width, default 17, giving the operand and difference bit width (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port A, input, width, the minuend.
REQ-005 The block SHALL have port B, input, width, the subtrahend.
REQ-006 The block SHALL have port bin, input, 1, the borrow-in.
REQ-007 The block SHALL have port in_valid, input, 1, asserted when A/B/bin hold a request.
REQ-008 The block SHALL have port in_ready, output, 1, asserted when a request is accepted this cycle.
REQ-009 The block SHALL have port D, output, width, the difference.
REQ-010 The block SHALL have port bout, output, 1, the borrow-out.
REQ-011 The block SHALL have port out_valid, output, 1, asserted when D/bout hold a result.
REQ-012 The block SHALL have port out_ready, input, 1, asserted when the consumer takes the result.

Function
REQ-013 The block SHALL compute {bout, D} such that D = (A - B - bin) mod 2^width and bout = 1 iff A < B + bin (unsigned).
REQ-014 The block SHALL implement the subtraction as A + ~B + ~bin through a Sklansky parallel-prefix carry tree, with bout = ~carry_out.
REQ-015 Stage 1 SHALL register the bitwise generate/propagate terms and the first ceil(log2(width))/2 prefix levels; stage 2 SHALL register the remaining levels, D and bout.
REQ-016 A request SHALL be accepted when in_valid && in_ready are both high at a rising edge.
REQ-017 An accepted request SHALL present its result with out_valid = 1 exactly 2 cycles after acceptance when out_ready is held high.
REQ-018 A result SHALL be consumed when out_valid && out_ready are both high at a rising edge.
REQ-019 Stage 2 SHALL load from stage 1 when stage 2 is empty or being consumed in the same cycle.
REQ-020 in_ready SHALL equal !v1 || !v2 || out_ready, where v1 and v2 are the stage valid flags; in_ready SHALL NOT depend on in_valid.
REQ-021 While out_valid = 1 and out_ready = 0, D and bout SHALL hold stable and no result SHALL be dropped or duplicated.
REQ-022 With in_valid and out_ready both held high, the block SHALL sustain one result per cycle.
REQ-023 Results SHALL leave in acceptance order; at most 2 requests SHALL be in flight.
REQ-024 Simultaneous accept and consume in one cycle SHALL both take effect, with occupancy unchanged.

Reset
REQ-025 On rst_n = 0 the block SHALL immediately clear v1, v2, out_valid, D, bout and all pipeline registers to 0, independent of clk.
REQ-026 In-flight requests SHALL be discarded when reset asserts mid-operation.
REQ-027 in_ready SHALL read 1 during reset and in the first cycle after reset deassertion.

Configuration
REQ-028 When macro PPA_SUB_OVF_EN is defined, the block SHALL add port ovf, output, 1, pipelined with D, equal to signed two's-complement overflow of A - B - bin, and reset to 0.
REQ-029 When PPA_SUB_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Basic case: A=0x00005, B=0x00003, bin=0, out_ready=1 -> D=0x00002, bout=0, out_valid high 2 cycles after accept.
REQ-031 Wrap-around case: A=0x00000, B=0x00001, bin=0 -> D=0x1FFFF, bout=1; A=0x1FFFF, B=0x1FFFF, bin=1 -> D=0x1FFFF, bout=1.
REQ-032 Backpressure: issue 3 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepts, D holds the first result; raise out_ready -> all 3 results appear in order.
REQ-033 Reset mid-flight: accept 2 requests, pulse rst_n low between clock edges -> out_valid=0 immediately; no stale result after release.
REQ-034 Random soak: 1000 random A/B/bin with random in_valid/out_ready -> every {bout, D} matches the reference model and arrives in order; with PPA_SUB_OVF_EN, A=0x0FFFF, B=0x10000, bin=0 -> ovf=1.
